trace_nibble_capture: RTL and testbench
=======================================

// Module: trace_nibble_capture
// PURPOSE
// - Receive side of the 4-bit TPIU-style trace port; the trace source drives TRACEDATA[3:0] with one nibble per clk.
// - Hunts for frame full-sync: 31 ones then a zero, seen as nibbles F,F,F,F,F,F,F,7.
// - After sync, pairs nibbles into bytes (low nibble first) and buffers them in a FIFO.
// - FIFO drains over a valid/ready stream to the capture/readout logic.
// PARAMETERS
// - FIFO_DEPTH  default 16  byte FIFO entries; power of 2, minimum 4.
// - TS_WIDTH    default 16  timestamp width; used only with TRACE_CAP_TIMESTAMP_EN.
// PORTS
// - clk         in   1         single clock; everything samples on posedge.
// - reset_n     in   1         asynchronous, active-low reset.
// - TRACEDATA   in   4         trace nibble, sampled every posedge clk.
// - capture_en  in   1         1 = capture; 0 = force HUNT, drop partial byte.
// - m_data      out  8         assembled trace byte at FIFO head.
// - m_valid     out  1         FIFO not empty.
// - m_ready     in   1         pop when m_valid & m_ready.
// - m_tstamp    out  TS_WIDTH  head entry timestamp; port exists only with TRACE_CAP_TIMESTAMP_EN.
// - locked      out  1         1 while in LOCKED state.
// - overflow    out  1         sticky; byte dropped because FIFO full.
// - ovf_clear   in   1         1-cycle pulse clears overflow.
// BEHAVIOUR
// - Reset values: m_valid=0, m_data=0, locked=0, overflow=0, FIFO empty, phase=LOW, ones_cnt=0.
// - Stage 0: TRACEDATA is registered into nib_q every cycle. All detection works on nib_q.
// - ones_cnt (3-bit, saturates at 7):
//     - nib_q==F: ones_cnt increments.
//     - any other value: ones_cnt clears to 0.
//     - sync_hit = (nib_q==7) & (ones_cnt==7).
// - FSM HUNT:
//     - Nothing is emitted.
//     - On sync_hit with capture_en=1: go to LOCKED, phase=LOW.
// - FSM LOCKED:
//     - phase LOW: latch nib_q as byte[3:0]; phase goes to HIGH.
//     - phase HIGH: byte = {nib_q, lo}; write to FIFO on the same edge; phase goes to LOW.
// - Sync while LOCKED:
//     - sync_hit forces phase=LOW on the next nibble.
//     - If sync_hit lands on phase HIGH: the 7 completes a byte normally (0x7F), written as data.
//     - If sync_hit lands on phase LOW: the held low nibble is discarded; no byte is written.
// - capture_en=0 in any state:
//     - Next state is HUNT; partial byte dropped; FIFO contents kept.
//     - ones_cnt keeps counting, so sync can be found immediately after re-enable.
// - Latency:
//     - Let the high nibble be on TRACEDATA during cycle N.
//     - It is in nib_q after edge N+1; FIFO write at edge N+2.
//     - m_valid=1 and m_data valid in cycle N+2 (first-word fall-through).
// - FIFO:
//     - FIFO_DEPTH entries; pointers one bit wider than the address for full/empty detection.
//     - Pointers wrap modulo 2*FIFO_DEPTH.
//     - Push and pop on the same edge: both are performed, count unchanged. This includes the full case, where the pop frees the slot so the push succeeds.
//     - Push when full with no pop: byte dropped, overflow<=1, FIFO unchanged.
//     - ovf_clear and a new overflow on the same edge: overflow stays 1 (set wins).
//     - m_data holds its last value when m_valid=0.
// - Reset assertion mid-frame (async):
//     - Immediate return to reset values; FIFO flushed.
//     - locked stays 0 until the next sync_hit.
// CONFIGURATION
// - TRACE_CAP_TIMESTAMP_EN defined:
//     - A free-running TS_WIDTH counter (reset 0, wraps) runs alongside capture.
//     - Its value at the FIFO-write edge is stored with each byte.
//     - It is presented on m_tstamp with the same valid/ready handshake as m_data.
// - TRACE_CAP_TIMESTAMP_EN undefined:
//     - No counter; no m_tstamp port; FIFO is 8 bits wide.
//     - All other behaviour is identical.
// TESTING
// - Basic assembly: capture_en=1, m_ready=1; nibbles F×7,7,1,2,3,4 -> locked=1; bytes 0x21 then 0x43, no others.
// - No false lock: F×6,7,1,2 -> locked stays 0, m_valid never asserts; then F×7,7 -> locked=1.
// - Realignment: while locked, send a lone nibble A then F×7,7,5,6.
//     - Phase becomes misaligned, so the 7 lands on phase LOW and is discarded.
//     - Last byte pushed is 0x65; no byte ever contains the A/F misalignment after the sync.
// - Overflow: FIFO_DEPTH=16, m_ready=0; push 17 bytes.
//     - m_valid=1, first 16 bytes kept in order, overflow=1.
//     - ovf_clear pulse -> overflow=0.
// - Full push+pop: FIFO full, m_ready=1 on the same edge a new byte arrives.
//     - overflow stays 0; count stays 16; order preserved.
// - Reset/disable: mid-byte (low nibble held), drive reset_n=0 between edges.
//     - m_valid and locked go 0 immediately.
//     - Repeat the test with capture_en=0 instead: locked=0 next edge; queued bytes remain poppable.
// - With TRACE_CAP_TIMESTAMP_EN defined: m_tstamp of successive bytes differs by 2 in continuous streaming.

Source files
------------

// File: rtl/trace_nibble_capture.sv
// Trace-port receiver: finds full-sync (F,F,F,F,F,F,F,7), packs nibble pairs into bytes, buffers them in a FWFT FIFO.
// Optional TRACE_CAP_TIMESTAMP_EN stores a free-running timestamp with each byte and exposes it on m_tstamp.
module trace_nibble_capture #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          TRACEDATA,
  input  logic                capture_en,
  output logic [7:0]          m_data,
  output logic                m_valid,
  input  logic                m_ready,
`ifdef TRACE_CAP_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0] m_tstamp,
`endif
  output logic                locked,
  output logic                overflow,
  input  logic                ovf_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef TRACE_CAP_TIMESTAMP_EN
  localparam int TSW = TS_WIDTH;
`else
  localparam int TSW = 0;
`endif
  localparam int EW = 8 + TSW;

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TS_WIDTH < 1) begin : g_bad_param
    $error("trace_nibble_capture: FIFO_DEPTH must be a power of 2 >= 4 and TS_WIDTH >= 1");
  end

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t          state_reg;
  logic            phase_reg;   // 0 = expecting low nibble, 1 = expecting high nibble
  logic [3:0]      nib_q;
  logic [3:0]      lo_reg;
  logic [2:0]      ones_cnt;
  logic            sync_hit;
  logic            push, pop, push_ok, full, empty;
  logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nib_q    <= 4'h0;
      ones_cnt <= 3'd0;
    end else begin
      nib_q <= TRACEDATA;
      if (nib_q == 4'hF) begin
        if (ones_cnt != 3'd7) ones_cnt <= ones_cnt + 3'd1;
      end else begin
        ones_cnt <= 3'd0;
      end
    end
  end

  assign sync_hit = (nib_q == 4'h7) && (ones_cnt == 3'd7);

  // A sync landing on the high phase completes a normal byte; on the low phase the held nibble is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= HUNT;
      phase_reg <= 1'b0;
      lo_reg    <= 4'h0;
    end else if (!capture_en) begin
      state_reg <= HUNT;
      phase_reg <= 1'b0;
    end else begin
      case (state_reg)
        HUNT: begin
          if (sync_hit) begin
            state_reg <= LOCKED;
            phase_reg <= 1'b0;
          end
        end
        LOCKED: begin
          if (phase_reg) begin
            phase_reg <= 1'b0;
          end else if (!sync_hit) begin
            lo_reg    <= nib_q;
            phase_reg <= 1'b1;
          end
        end
        default: state_reg <= HUNT;
      endcase
    end
  end

  assign locked = (state_reg == LOCKED);
  assign push   = capture_en && (state_reg == LOCKED) && phase_reg;

`ifdef TRACE_CAP_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 1'b1;
  end

  assign wr_entry = {ts_cnt, nib_q, lo_reg};
  assign m_tstamp = head_reg[EW-1:8];
`else
  assign wr_entry = {nib_q, lo_reg};
`endif

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign m_valid     = !empty;
  assign pop         = m_valid && m_ready;
  assign push_ok     = push && (!full || pop);
  assign wr_ptr_next = wr_ptr + {{AW{1'b0}}, push_ok};
  assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, pop};
  assign m_data      = head_reg[7:0];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  // head_reg is the registered FIFO head; it bypasses the array when the new head is the entry being written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head_reg <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      if (rd_ptr_next != wr_ptr_next) begin
        if (rd_ptr_next == wr_ptr) head_reg <= wr_entry;
        else                       head_reg <= mem[rd_ptr_next[AW-1:0]];
      end
      if (push && full && !pop) overflow <= 1'b1;
      else if (ovf_clear)       overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trace_nibble_capture.sv
// Randomised scoreboard bench for trace_nibble_capture: a nibble-stream reference model predicts bytes, lock and overflow.
module tb_trace_nibble_capture;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] TRACEDATA = 4'h0;
  logic       capture_en = 1'b0;
  logic       m_ready = 1'b0;
  logic       ovf_clear = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       locked;
  logic       overflow;
`ifdef TRACE_CAP_TIMESTAMP_EN
  logic [15:0] m_tstamp;
`endif

  trace_nibble_capture #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .TRACEDATA  (TRACEDATA),
    .capture_en (capture_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
`ifdef TRACE_CAP_TIMESTAMP_EN
    .m_tstamp   (m_tstamp),
`endif
    .locked     (locked),
    .overflow   (overflow),
    .ovf_clear  (ovf_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned ts;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  // Reference model state: stream-level view of the trace port.
  int          run_len;
  bit          mdl_locked;
  bit          have_lo;
  logic [3:0]  lo_nib;
  logic [3:0]  prev_nib;
  int          cnt_now, cnt_after;
  bit          lock_now, lock_after, ovf_now, ovf_after;
  int unsigned ts_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      check("m_valid", 32'(m_valid), 32'(cnt_now > 0));
      check("locked", 32'(locked), 32'(lock_now));
      check("overflow", 32'(overflow), 32'(ovf_now));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e.data));
`ifdef TRACE_CAP_TIMESTAMP_EN
          check("m_tstamp", 32'(m_tstamp), e.ts & 32'hFFFF);
`endif
        end
      end
    end
  end

  task automatic model_reset();
    run_len    = 0;
    mdl_locked = 1'b0;
    have_lo    = 1'b0;
    lo_nib     = 4'h0;
    prev_nib   = 4'h0;
    cnt_now    = 0;
    cnt_after  = 0;
    lock_now   = 1'b0;
    lock_after = 1'b0;
    ovf_now    = 1'b0;
    ovf_after  = 1'b0;
    ts_model   = 0;
    exp_q.delete();
  endtask

  // One nibble of the trace stream, as seen with the capture_en that applies when it is consumed.
  task automatic model_step(input logic [3:0] nib, input bit cen, output bit emit, output logic [7:0] b);
    bit sync;
    sync = (nib == 4'h7) && (run_len >= 7);
    run_len = (nib == 4'hF) ? run_len + 1 : 0;
    emit = 1'b0;
    b = 8'h00;
    if (!cen) begin
      mdl_locked = 1'b0;
      have_lo = 1'b0;
    end else if (!mdl_locked) begin
      if (sync) begin
        mdl_locked = 1'b1;
        have_lo = 1'b0;
      end
    end else if (!have_lo) begin
      if (!sync) begin
        lo_nib = nib;
        have_lo = 1'b1;
      end
    end else begin
      emit = 1'b1;
      b = {nib, lo_nib};
      have_lo = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    model_reset();
    TRACEDATA  = 4'h0;
    capture_en = 1'b0;
    ovf_clear  = 1'b0;
    mon_en     = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic cycle(input logic [3:0] nib, input bit cen, input bit rdy, input bit clr = 1'b0);
    bit         emit, pop, dropped;
    logic [7:0] b;
    @(posedge clk);
    #2;
    cnt_now  = cnt_after;
    lock_now = lock_after;
    ovf_now  = ovf_after;
    TRACEDATA  = nib;
    capture_en = cen;
    m_ready    = rdy;
    ovf_clear  = clr;
    ts_model++;
    model_step(prev_nib, cen, emit, b);
    pop = (cnt_now > 0) && rdy;
    dropped = 1'b0;
    cnt_after = cnt_now;
    if (emit) begin
      if (cnt_now < DEPTH || pop) begin
        exp_q.push_back('{data: b, ts: ts_model});
        cnt_after++;
      end else begin
        dropped = 1'b1;
      end
    end
    if (pop) cnt_after--;
    ovf_after  = dropped ? 1'b1 : (clr ? 1'b0 : ovf_now);
    lock_after = mdl_locked;
    prev_nib   = nib;
  endtask

  task automatic sync_seq(input bit rdy);
    for (int i = 0; i < 7; i++) cycle(4'hF, 1'b1, rdy);
    cycle(4'h7, 1'b1, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(4'h0, 1'b0, rdy);
  endtask

  initial begin
    do_reset();

    // Basic assembly: 0x21, 0x43
    cycle(4'h0, 1'b1, 1'b1);
    sync_seq(1'b1);
    cycle(4'h1, 1'b1, 1'b1);
    cycle(4'h2, 1'b1, 1'b1);
    cycle(4'h3, 1'b1, 1'b1);
    cycle(4'h4, 1'b1, 1'b1);
    cycle(4'h0, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Six ones then 7 must not lock; seven then 7 must
    cycle(4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(4'hF, 1'b1, 1'b1);
    cycle(4'h7, 1'b1, 1'b1);
    cycle(4'h1, 1'b1, 1'b1);
    cycle(4'h2, 1'b1, 1'b1);
    sync_seq(1'b1);
    cycle(4'h9, 1'b1, 1'b1);
    cycle(4'h8, 1'b1, 1'b1);

    // Realignment: lone A shifts phase, the sync then lands on the low phase
    cycle(4'hA, 1'b1, 1'b1);
    sync_seq(1'b1);
    cycle(4'h5, 1'b1, 1'b1);
    cycle(4'h6, 1'b1, 1'b1);
    cycle(4'h0, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Randomised stream with occasional syncs, disables, back-pressure and clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        sync_seq(1'($urandom_range(0, 1)));
      end else begin
        cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 19) != 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
      end
    end
    idle(DEPTH + 4, 1'b1);

    // Overflow: 17 bytes with no reads, then clear and drain
    do_reset();
    sync_seq(1'b0);
    for (int i = 0; i < 34; i++) cycle(4'(i), 1'b1, 1'b0);
    cycle(4'h0, 1'b1, 1'b0);
    idle(3, 1'b0);
    cycle(4'h0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(DEPTH + 4, 1'b1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    sync_seq(1'b0);
    for (int i = 0; i < 2 * DEPTH; i++) cycle(4'($urandom_range(0, 15)), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(4'($urandom_range(0, 15)), 1'b1, 1'b1);
    cycle(4'h0, 1'b1, 1'b1);
    idle(DEPTH + 4, 1'b1);

    // Reset with a low nibble held, then relock
    sync_seq(1'b1);
    cycle(4'h1, 1'b1, 1'b0);
    cycle(4'h2, 1'b1, 1'b0);
    cycle(4'h3, 1'b1, 1'b0);
    do_reset();
    sync_seq(1'b1);
    cycle(4'hC, 1'b1, 1'b1);
    cycle(4'hD, 1'b1, 1'b1);
    cycle(4'h0, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Disable mid-byte: lock drops, queued bytes stay poppable
    sync_seq(1'b0);
    for (int i = 1; i <= 5; i++) cycle(4'(i), 1'b1, 1'b0);
    cycle(4'h6, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(DEPTH + 4, 1'b1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
